// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU constants and the fetch-entry type
package cpu_pkg;

    localparam int          WORD_W  = 32;
    localparam logic [31:0] PC_STEP = 32'd4;
    // Architectural register index that aliases the program counter
    localparam int          PC_IDX  = 15;

    typedef struct packed {
        logic [WORD_W-1:0] pc;
        logic [WORD_W-1:0] word;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - instruction memory, redirect and decode-side signals of the fetch unit
interface fetch_unit_if
    import cpu_pkg::*;
#(
    parameter int MEM_AW = 6
);

    logic [MEM_AW-1:0] mem_addr;
    logic [WORD_W-1:0] mem_rdata;
    logic              redirect_valid;
    logic [WORD_W-1:0] redirect_pc;
    logic              instr_valid;
    logic              instr_ready;
    logic [WORD_W-1:0] instr;
    logic [WORD_W-1:0] instr_pc;
    logic [WORD_W-1:0] pc;

    modport master (
        output mem_addr,
        input  mem_rdata,
        input  redirect_valid,
        input  redirect_pc,
        output instr_valid,
        input  instr_ready,
        output instr,
        output instr_pc,
        output pc
    );

    modport slave (
        input  mem_addr,
        output mem_rdata,
        output redirect_valid,
        output redirect_pc,
        input  instr_valid,
        output instr_ready,
        input  instr,
        input  instr_pc,
        input  pc
    );

endinterface

// File: rtl/fetch_buffer.sv
// rtl/fetch_buffer.sv - small shift-register FIFO of fetched {pc, word} entries with flush
module fetch_buffer
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush_i,
    input  logic         push_i,
    input  fetch_entry_t push_entry_i,
    input  logic         pop_i,
    output logic [CW-1:0] count_o,
    output fetch_entry_t head_o,
    output logic         head_valid_o
);

    fetch_entry_t    mem_q [DEPTH];
    fetch_entry_t    mem_d [DEPTH];
    logic [CW-1:0]   count_q;
    logic [CW-1:0]   count_d;
    int              wr_idx;

    // Next-state: flush wins; otherwise shift on pop, then write the push into the first free slot
    always_comb begin
        mem_d   = mem_q;
        count_d = count_q;
        wr_idx  = int'(count_q);
        if (flush_i) begin
            count_d = '0;
        end else begin
            if (pop_i) begin
                for (int i = 0; i < DEPTH - 1; i++) begin
                    mem_d[i] = mem_q[i + 1];
                end
                wr_idx = int'(count_q) - 1;
            end
            if (push_i) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (i == wr_idx) begin
                        mem_d[i] = push_entry_i;
                    end
                end
            end
            count_d = CW'(wr_idx + (push_i ? 1 : 0));
        end
    end

    // Storage and occupancy registers; reset clears the head so instr/instr_pc read zero
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            count_q <= count_d;
            mem_q   <= mem_d;
        end
    end

    assign count_o      = count_q;
    assign head_o       = mem_q[0];
    assign head_valid_o = (count_q != '0);

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC sequencing and prefetch buffer; FETCH_PREFETCH_EN selects a 2-entry buffer
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          MEM_AW   = 6
) (
    input  logic         clk,
    input  logic         reset,
    fetch_unit_if.master bus
);

`ifdef FETCH_PREFETCH_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif
    localparam int            CW      = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [WORD_W-1:0] pc_q;
    logic [WORD_W-1:0] pc_d;
    logic [CW-1:0]     count;
    fetch_entry_t      head;
    fetch_entry_t      push_entry;
    logic              head_valid;
    logic              transfer;
    logic              fetch;

    // Fetch decision and next PC; a redirect suppresses the fetch and realigns the target
    always_comb begin
        transfer   = head_valid && bus.instr_ready;
        fetch      = !bus.redirect_valid && ((count < DEPTH_C) || transfer);
        push_entry = '{pc: pc_q, word: bus.mem_rdata};
        pc_d       = pc_q;
        if (bus.redirect_valid) begin
            pc_d = {bus.redirect_pc[31:2], 2'b00};
        end else if (fetch) begin
            pc_d = pc_q + PC_STEP;
        end
    end

    // Program counter register
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= RESET_PC & ~32'h3;
        end else begin
            pc_q <= pc_d;
        end
    end

    fetch_buffer #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_buffer (
        .clk          (clk),
        .reset        (reset),
        .flush_i      (bus.redirect_valid),
        .push_i       (fetch),
        .push_entry_i (push_entry),
        .pop_i        (transfer),
        .count_o      (count),
        .head_o       (head),
        .head_valid_o (head_valid)
    );

    assign bus.mem_addr    = pc_q[MEM_AW+1:2];
    assign bus.pc          = pc_q;
    assign bus.instr_valid = head_valid;
    assign bus.instr       = head.word;
    assign bus.instr_pc    = head.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;

`ifdef FETCH_PREFETCH_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;
    int   xfer_cnt;
    int   n0;
    logic [31:0] last_xfer_pc;
    logic [31:0] mem [64];

    fetch_unit_if #(.MEM_AW(6)) bus ();

    fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .MEM_AW   (6)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input int idx);
        case (idx)
            0:       return 32'hE3A0_0001;
            1:       return 32'hE3A0_1002;
            2:       return 32'hE080_2001;
            3:       return 32'hEAFF_FFFE;
            default: return 32'hA500_0000 | 32'(idx);
        endcase
    endfunction

    assign bus.mem_rdata = mem[bus.mem_addr];

    // Transfer log, sampled mid-cycle while inputs and registered outputs are stable
    always @(negedge clk) begin
        if (!reset && bus.instr_valid && bus.instr_ready) begin
            xfer_cnt     = xfer_cnt + 1;
            last_xfer_pc = bus.instr_pc;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks           = 0;
        n_errors           = 0;
        xfer_cnt           = 0;
        last_xfer_pc       = 32'h0;
        reset              = 1'b1;
        bus.instr_ready    = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        for (int i = 0; i < 64; i++) mem[i] = mem_word(i);

        step();
        step();
        check("rst_valid", 32'(bus.instr_valid), 32'h0);
        check("rst_instr", bus.instr, 32'h0);
        check("rst_ipc", bus.instr_pc, 32'h0);
        check("rst_pc", bus.pc, 32'h0);
        check("rst_addr", 32'(bus.mem_addr), 32'h0);

        // Streaming from reset release
        reset = 1'b0;
        bus.instr_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            check("stream_valid", 32'(bus.instr_valid), 32'h1);
            check("stream_ipc", bus.instr_pc, 32'(4 * k));
            check("stream_instr", bus.instr, mem_word(k));
        end

        // Stall, then reset mid-stream
        bus.instr_ready = 1'b0;
        step();
        step();
        check("stall_ipc", bus.instr_pc, 32'hC);
        check("stall_pc", bus.pc, (DEPTH == 2) ? 32'h14 : 32'h10);
        reset = 1'b1;
        step();
        check("midrst_valid", 32'(bus.instr_valid), 32'h0);
        check("midrst_pc", bus.pc, 32'h0);
        check("midrst_ipc", bus.instr_pc, 32'h0);
        reset = 1'b0;
        bus.instr_ready = 1'b1;
        step();
        check("restart_ipc0", bus.instr_pc, 32'h0);
        check("restart_instr0", bus.instr, mem_word(0));
        step();
        check("restart_ipc4", bus.instr_pc, 32'h4);

        // Hold ready low for 5 cycles after release
        reset = 1'b1;
        bus.instr_ready = 1'b0;
        step();
        reset = 1'b0;
        for (int k = 0; k < 5; k++) step();
        check("hold_valid", 32'(bus.instr_valid), 32'h1);
        check("hold_ipc", bus.instr_pc, 32'h0);
        check("hold_pc", bus.pc, (DEPTH == 2) ? 32'h8 : 32'h4);
        bus.instr_ready = 1'b1;
        step();
        check("resume_valid4", 32'(bus.instr_valid), 32'h1);
        check("resume_ipc4", bus.instr_pc, 32'h4);
        step();
        check("resume_valid8", 32'(bus.instr_valid), 32'h1);
        check("resume_ipc8", bus.instr_pc, 32'h8);

        // Redirect to a misaligned target while the buffer is full
        bus.instr_ready = 1'b0;
        step();
        step();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_0012;
        step();
        bus.redirect_valid = 1'b0;
        check("redir_valid", 32'(bus.instr_valid), 32'h0);
        check("redir_pc", bus.pc, 32'h10);
        check("redir_addr", 32'(bus.mem_addr), 32'h4);
        step();
        check("redir_hvalid", 32'(bus.instr_valid), 32'h1);
        check("redir_ipc", bus.instr_pc, 32'h10);
        check("redir_instr", bus.instr, mem_word(4));
        check("redir_pc2", bus.pc, 32'h14);

        // Memory index wrap past the last word
        bus.instr_ready    = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_00FC;
        step();
        bus.redirect_valid = 1'b0;
        check("wrap_valid0", 32'(bus.instr_valid), 32'h0);
        check("wrap_addr63", 32'(bus.mem_addr), 32'd63);
        step();
        check("wrap_ipcFC", bus.instr_pc, 32'hFC);
        check("wrap_instr63", bus.instr, mem_word(63));
        check("wrap_addr0", 32'(bus.mem_addr), 32'h0);
        step();
        check("wrap_ipc100", bus.instr_pc, 32'h100);
        check("wrap_instr0", bus.instr, mem_word(0));
        check("wrap_addr1", 32'(bus.mem_addr), 32'h1);

        // Transfer and redirect in the same cycle on a full buffer
        bus.instr_ready = 1'b0;
        step();
        step();
        n0 = xfer_cnt;
        bus.instr_ready    = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_0020;
        step();
        bus.redirect_valid = 1'b0;
        check("rx_xfer1", 32'(xfer_cnt - n0), 32'h1);
        check("rx_xfer_pc", last_xfer_pc, 32'h100);
        check("rx_valid", 32'(bus.instr_valid), 32'h0);
        step();
        check("rx_ipc20", bus.instr_pc, 32'h20);
        check("rx_xfer1b", 32'(xfer_cnt - n0), 32'h1);
        step();
        check("rx_xfer2", 32'(xfer_cnt - n0), 32'h2);
        check("rx_last20", last_xfer_pc, 32'h20);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset (bits [1:0] ignored).
REQ-002 Parameter MEM_AW, default 6, word-address width of instruction memory (64 words).
REQ-003 clk  input  1  single clock, all state updates on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 mem_addr  output  MEM_AW  word address to instruction memory, equals pc[MEM_AW+1:2].
REQ-006 mem_rdata  input  32  instruction word, combinational read of mem_addr in the same cycle.
REQ-007 redirect_valid  input  1  branch/PC-write request from execute.
REQ-008 redirect_pc  input  32  new PC, byte address.
REQ-009 instr_valid  output  1  buffer head holds a valid instruction.
REQ-010 instr_ready  input  1  decoder accepts the head this cycle.
REQ-011 instr  output  32  head instruction word.
REQ-012 instr_pc  output  32  byte address of the head instruction.
REQ-013 pc  output  32  address of the next fetch.

Function
REQ-014 Prefetch buffer: FIFO of DEPTH entries {pc, word}; DEPTH=2, or 1 per REQ-029/030.
REQ-015 instr_valid, instr and instr_pc driven only from registers; no combinational path from any input.
REQ-016 Transfer occurs when instr_valid && instr_ready; the head is popped at that posedge.
REQ-017 Fetch occurs in a cycle when not reset, not redirect_valid, and (count < DEPTH or a transfer occurs).
REQ-018 On fetch: push {pc, mem_rdata}; pc <= pc + 4, modulo 2^32.
REQ-019 Fetch-to-valid latency 1 cycle: a word fetched in cycle N is visible at the head in cycle N+1 if the buffer was empty.
REQ-020 Full and transfer in the same cycle: pop and push both happen, count unchanged.
REQ-021 Full without transfer: no fetch; pc, mem_addr and buffer contents hold.
REQ-022 Empty: instr_valid=0; instr and instr_pc hold their last values and are don't-care.
REQ-023 redirect_valid has priority over fetch and push: buffer flushed (count=0), pc <= {redirect_pc[31:2],2'b00}, no push that cycle.
REQ-024 A transfer in a redirect cycle counts as consumed; the remaining entries are discarded.
REQ-025 First fetch from the redirect target occurs in the cycle after the redirect; instr_valid is 0 in that cycle.
REQ-026 Memory index wraps: pc 0x100 with MEM_AW=6 reads word 0, because only pc[7:2] address memory.

Reset
REQ-027 While reset=1: pc=RESET_PC & ~3, count=0, instr_valid=0, instr=0, instr_pc=0; redirect and transfer are ignored.
REQ-028 First fetch is in the first cycle with reset=0; reset asserted mid-stream discards all buffered entries at that posedge.

Configuration
REQ-029 Macro FETCH_PREFETCH_EN defined: DEPTH=2, so back-to-back transfers sustain 1 instruction/cycle.
REQ-030 Macro FETCH_PREFETCH_EN undefined: DEPTH=1, single register; fetch only when empty or transferring, same ordering and redirect rules.

Structure
REQ-031 Shared package cpu_pkg holds the WORD_W=32 constant, PC_STEP=4, the PC index constant 15, and the fetch-entry struct {pc, word}.
REQ-032 One sub-module fetch_buffer (parameterised DEPTH FIFO with push/pop/flush, count, head outputs); PC logic stays in fetch_unit.

Verification
REQ-033 Memory words 0..3 = 0xE3A00001, 0xE3A01002, 0xE0802001, 0xEAFFFFFE; reset released, instr_ready=1 -> instr_pc 0,4,8,12 and instr values in order, on consecutive cycles starting 1 cycle after release.
REQ-034 instr_ready=0 for 5 cycles after release -> instr_valid=1 with instr_pc=0, pc=8 with DEPTH=2 (pc=4 with DEPTH=1); then ready=1 -> instr_pc 0,4,8 with no gap or duplicate.
REQ-035 redirect_valid=1, redirect_pc=0x0000_0012 while 2 entries are buffered -> next cycle instr_valid=0 and pc advances to 0x14 after fetching 0x10; following cycle instr_pc=0x10.
REQ-036 redirect_pc=0xFC, then run 2 cycles -> fetch words 63 and 0; instr_pc 0xFC then 0x100.
REQ-037 reset pulsed for 1 cycle mid-stream with 2 entries buffered -> instr_valid=0 the next cycle, pc=RESET_PC, then the stream restarts at instr_pc 0.
REQ-038 Full buffer, instr_ready=1 and redirect_valid=1 in the same cycle -> exactly one transfer logged, and no entry with the old pc appears afterwards.
